seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds one 4-bit code per digit, drives a single shared `bin2seg` decoder through `bin_out`, and enables one digit at a time. A blanking gap separates digit slots to suppress ghosting. Host updates arrive through a valid/ready write port and are applied only at frame boundaries, so a frame never mixes old and new digits.

## Interface
Parameters:
- `NUM_DIGITS`, 4: number of digits scanned; must be at least 2.
- `ON_CYCLES`, 50000: clocks each digit is enabled; must be at least 1.
- `BLANK_CYCLES`, 500: clocks all digits are off between slots; must be at least 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_valid`  in  1  host presents a new display value.
- `wr_data`  in  4*NUM_DIGITS  nibble i = code for digit i; digit 0 is least significant.
- `wr_ready`  out  1  controller can accept a write.
- `lz_en`  in  1  leading-zero suppression enable, sampled live.
- `bin_out`  out  4  code for the current digit, to the shared decoder.
- `dig_n`  out  NUM_DIGITS  active-low digit enables; at most one bit is low.
- `frame_start`  out  1  one-cycle pulse on the first ON cycle of digit 0.

## Operation
- Registers:
  - `active`: displayed value.
  - `shadow`: pending value.
  - `pending`: flag, set while `shadow` holds an unapplied write.
  - `idx`: current digit, range 0..NUM_DIGITS-1.
  - `cnt`: slot counter.
  - `state`: ON or BLANK.
- Reset values:
  - `state` = BLANK, `idx` = NUM_DIGITS-1, `cnt` = 0.
  - `active` = 0, `shadow` = 0, `pending` = 0.
  - Outputs: `dig_n` all ones, `bin_out` = 0, `wr_ready` = 1, `frame_start` = 0.
- FSM:
  - ON: `dig_n[idx]` is low unless the digit is suppressed. When `cnt` = ON_CYCLES-1, go to BLANK and clear `cnt`.
  - BLANK: `dig_n` is all ones. When `cnt` = BLANK_CYCLES-1, go to ON, clear `cnt`, and set `idx` to (`idx`+1) mod NUM_DIGITS.
- Frame boundary: the BLANK→ON transition where `idx` wraps from NUM_DIGITS-1 to 0.
  - If `pending` = 1 on that edge: `active` takes `shadow` and `pending` clears.
  - The new value is therefore visible from the first ON cycle of digit 0.
- Write handshake:
  - `wr_ready` = !`pending`.
  - A write is accepted on any edge where `wr_valid` and `wr_ready` are both 1: `shadow` takes `wr_data` and `pending` is set.
  - `wr_data` is ignored while `wr_ready` = 0. The host holds `wr_valid` until accepted.
- Simultaneous accept and frame boundary: the boundary sees `pending` = 0, so `active` is unchanged. The accepted data is applied at the next boundary.
- `bin_out` = `active` nibble at `idx`, in both states (combinational from registers).
- Leading-zero suppression, when `lz_en` = 1:
  - Digit i is suppressed when i > 0 and nibbles i through NUM_DIGITS-1 of `active` are all zero.
  - A suppressed digit keeps `dig_n` all ones during its ON slot; slot timing is unchanged.
  - Digit 0 is never suppressed.
- Reset asserted mid-frame: all registers return to reset values immediately, and any pending write is discarded.

## Timing
- Slot length: ON_CYCLES + BLANK_CYCLES clocks.
- Frame length: NUM_DIGITS × (ON_CYCLES + BLANK_CYCLES) clocks.
- First ON cycle of digit 0 occurs BLANK_CYCLES clocks after `rst_n` deasserts.
- `frame_start` is a registered pulse, high exactly during the first ON cycle of digit 0 of each frame.
- Write-to-display latency: from the accept edge to the next frame boundary; at most one frame plus one clock.
- `cnt` width: $clog2 of max(ON_CYCLES, BLANK_CYCLES); no overflow is possible.
- `dig_n` and `bin_out` change only on clock edges, as combinational decode of registered state.
- No cycle ever has two `dig_n` bits low.

## Test plan
All scenarios use NUM_DIGITS=4, ON_CYCLES=4, BLANK_CYCLES=2.
- Reset and idle scan:
  - Stimulus: release reset, no writes.
  - Response: `dig_n`=4'b1111 for 2 clocks, then 4'b1110 for 4 clocks, 4'b1111 for 2, then 4'b1101.
  - `frame_start` pulses every 24 clocks; `bin_out`=0 throughout.
- Basic write:
  - Stimulus: write 16'h1234 one clock after reset release.
  - Response: `wr_ready` drops the next cycle. At the first frame boundary `bin_out` = 4, 3, 2, 1 on digits 0 to 3, and `wr_ready` returns to 1.
- Backpressure:
  - Stimulus: write 16'hAAAA, then hold `wr_valid` with 16'h5555 while `pending`=1.
  - Response: 16'h5555 is accepted on the boundary edge's following cycle. The display shows AAAA for one full frame, then 5555.
- Write on the boundary edge:
  - Stimulus: accept 16'h00F0 on the exact digit-3 BLANK→ON edge.
  - Response: that frame still shows the old value; 00F0 appears one frame later.
- Leading-zero suppression:
  - Stimulus: `active`=16'h0007 with `lz_en`=1.
  - Response: only digit 0 is enabled; digits 1 to 3 keep `dig_n` high in their slots. With `lz_en`=0, all 4 digits are enabled and digits 1 to 3 show 0.
- Mid-frame reset:
  - Stimulus: assert `rst_n` low during the digit-2 ON slot with a write pending.
  - Response: `dig_n`=4'b1111 immediately and `wr_ready`=1. After release, `bin_out`=0 and the pending write is not displayed.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned host updates
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_valid,
    input  logic [4*NUM_DIGITS-1:0] wr_data,
    output logic                    wr_ready,
    input  logic                    lz_en,
    output logic [3:0]              bin_out,
    output logic [NUM_DIGITS-1:0]   dig_n,
    output logic                    frame_start
);

    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int IDX_W   = $clog2(NUM_DIGITS);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_ON    = 1'b1;

    logic [0:0]              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] active_q, active_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic                    pending_q, pending_d;
    logic                    frame_start_q;
    logic                    boundary;
    logic                    accept;
    logic [NUM_DIGITS-1:0]   supp;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        boundary = 1'b0;
        if (state_q == ST_ON) begin
            if (cnt_q == CNT_W'(ON_CYCLES - 1)) begin
                state_d = ST_BLANK;
                cnt_d   = '0;
            end
        end else if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
            state_d = ST_ON;
            cnt_d   = '0;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
                idx_d    = '0;
                boundary = 1'b1;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Accept and apply are exclusive: accept needs pending low, apply needs it high.
    always_comb begin
        accept    = wr_valid && !pending_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        if (boundary && pending_q) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (accept) begin
            shadow_d  = wr_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BLANK;
            cnt_q         <= '0;
            idx_q         <= IDX_W'(NUM_DIGITS - 1);
            active_q      <= '0;
            shadow_q      <= '0;
            pending_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            pending_q     <= pending_d;
            frame_start_q <= boundary;
        end
    end

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        supp     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero = all_zero && (active_q[4*i +: 4] == 4'd0);
            supp[i]  = lz_en && (i != 0) && all_zero;
        end
    end

    always_comb begin
        dig_n = '1;
        if (state_q == ST_ON && !supp[idx_q]) begin
            dig_n[idx_q] = 1'b0;
        end
    end

    assign bin_out     = active_q[4*idx_q +: 4];
    assign wr_ready    = !pending_q;
    assign frame_start = frame_start_q;

endmodule
